// File: rtl/srff_pkg.sv
// Shared definitions for the SR flop command driver:
// SR code values and FSM state encoding.
package srff_pkg;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_CLR     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_DRIVE  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

endpackage

// File: rtl/srff_cmd_encode.sv
// Per-bit SR command generation for a masked target write.
// data_i/mask_i/shadow_i in, cmd_o (2 bits per flop) and any_o out.
module srff_cmd_encode
  import srff_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]   data_i,
  input  logic [N-1:0]   mask_i,
  input  logic [N-1:0]   shadow_i,
  output logic [2*N-1:0] cmd_o,
  output logic           any_o
);

  always_comb begin
    cmd_o = '0;
    for (int i = 0; i < N; i++) begin
      unique case (1'b1)
        mask_i[i] & data_i[i] & ~shadow_i[i]:
          cmd_o[2*i +: 2] = SR_SET;
        mask_i[i] & ~data_i[i] & shadow_i[i]:
          cmd_o[2*i +: 2] = SR_CLR;
        default:
          cmd_o[2*i +: 2] = SR_HOLD;
      endcase
    end
    any_o = |cmd_o;
  end

endmodule

// File: rtl/srff_cmd_driver.sv
// Write-side driver for a bank of N SR flops: handshake in, SR codes out.
// Ports: clk, rst, in_* write, sr_out, shadow, busy, done, q_fb, mismatch.
// Macro SRFF_CMD_DRIVER_CHECK_EN enables the q_fb vs shadow comparator.
module srff_cmd_driver
  import srff_pkg::*;
#(
  parameter int N           = 8,
  parameter int HOLD_CYCLES = 1,
  parameter int CW          = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic [N-1:0]   in_mask,
  output logic [2*N-1:0] sr_out,
  output logic [N-1:0]   shadow,
  output logic           busy,
  output logic           done,
  input  logic [N-1:0]   q_fb,
  output logic           mismatch
);

  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);

  state_e         state_q;
  logic [2*N-1:0] sr_q;
  logic [N-1:0]   shadow_q;
  logic           busy_q;
  logic           done_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] cmd;
  logic           any_chg;
  logic [N-1:0]   shadow_d;

  srff_cmd_encode #(.N(N)) u_enc (
    .data_i   (in_data),
    .mask_i   (in_mask),
    .shadow_i (shadow_q),
    .cmd_o    (cmd),
    .any_o    (any_chg)
  );

  assign shadow_d = (shadow_q & ~in_mask) | (in_data & in_mask);

  // Outputs are registered alongside the state, so they line up
  // with the state the FSM is in during each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      sr_q     <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_INIT: begin
          // cnt 1..HOLD marks the cycles that show the clear code
          if (cnt_q == HOLD_C) begin
            state_q <= ST_SETTLE;
            sr_q    <= '0;
            cnt_q   <= '0;
          end else begin
            sr_q  <= {N{SR_CLR}};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (in_valid) begin
            shadow_q <= shadow_d;
            if (any_chg) begin
              state_q <= ST_DRIVE;
              sr_q    <= cmd;
              cnt_q   <= CW'(1);
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt_q == HOLD_C) begin
            state_q <= ST_SETTLE;
            sr_q    <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          sr_q    <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef SRFF_CMD_DRIVER_CHECK_EN
  logic mis_q;

  // Flops have had a full cycle of hold by SETTLE, so q_fb is stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (state_q == ST_SETTLE && q_fb != shadow_q) begin
      mis_q <= 1'b1;
    end
  end

  assign mismatch = mis_q;
`else
  logic unused_q_fb;

  assign unused_q_fb = ^q_fb;
  assign mismatch    = 1'b0;
`endif

  assign in_ready = (state_q == ST_IDLE);
  assign sr_out   = sr_q;
  assign shadow   = shadow_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_srff_cmd_driver.sv
// Directed self-checking bench for srff_cmd_driver.
// Two instances: HOLD_CYCLES=1 (dut) and HOLD_CYCLES=3 (dut3).
module tb_srff_cmd_driver;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst, rst3;
  logic           in_valid, in_valid3;
  logic           in_ready, in_ready3;
  logic [N-1:0]   in_data, in_data3;
  logic [N-1:0]   in_mask, in_mask3;
  logic [2*N-1:0] sr_out, sr_out3;
  logic [N-1:0]   shadow, shadow3;
  logic           busy, busy3;
  logic           done, done3;
  logic [N-1:0]   q_fb, q_fb3;
  logic           mismatch, mismatch3;

  logic [N-1:0]   bank  = '0;
  logic [N-1:0]   bank3 = '0;
  logic [N-1:0]   stuck = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  srff_cmd_driver #(.N(N), .HOLD_CYCLES(1), .CW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .sr_out(sr_out),
    .shadow(shadow), .busy(busy), .done(done), .q_fb(q_fb),
    .mismatch(mismatch)
  );

  srff_cmd_driver #(.N(N), .HOLD_CYCLES(3), .CW(4)) dut3 (
    .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_mask(in_mask3), .sr_out(sr_out3),
    .shadow(shadow3), .busy(busy3), .done(done3), .q_fb(q_fb3),
    .mismatch(mismatch3)
  );

  // Behavioural SR flop banks driven by the DUT codes.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (sr_out[2*i +: 2] == 2'b10) bank[i] <= 1'b1;
      else if (sr_out[2*i +: 2] == 2'b01) bank[i] <= 1'b0;
      if (sr_out3[2*i +: 2] == 2'b10) bank3[i] <= 1'b1;
      else if (sr_out3[2*i +: 2] == 2'b01) bank3[i] <= 1'b0;
    end
  end

  assign q_fb  = bank & ~stuck;
  assign q_fb3 = bank3;

  function automatic logic has11(logic [2*N-1:0] v);
    has11 = 1'b0;
    for (int i = 0; i < N; i++)
      if (v[2*i +: 2] == 2'b11) has11 = 1'b1;
  endfunction

  always @(negedge clk) begin
    n_checks++;
    assert (has11(sr_out) === 1'b0) else begin
      n_fail++;
      $error("FAIL no11_dut: observed %h expected no 11 code", sr_out);
    end
    n_checks++;
    assert (has11(sr_out3) === 1'b0) else begin
      n_fail++;
      $error("FAIL no11_dut3: observed %h expected no 11 code", sr_out3);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    in_valid = 1'b0; in_data = '0; in_mask = '0;
    in_valid3 = 1'b0; in_data3 = '0; in_mask3 = '0;
    tick(); tick();
    chk("rst_sr", 32'(sr_out), 32'h0);
    chk("rst_shadow", 32'(shadow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_mis", 32'(mismatch), 32'h0);
    rst = 1'b0;

    // INIT: 01 for one cycle, 00 for one, then done
    tick();
    chk("init_clr", 32'(sr_out), 32'h5555);
    chk("init_ready", 32'(in_ready), 32'h0);
    tick();
    chk("init_settle_sr", 32'(sr_out), 32'h0);
    chk("init_settle_done", 32'(done), 32'h0);
    tick();
    chk("init_done", 32'(done), 32'h1);
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_ready1", 32'(in_ready), 32'h1);
    chk("init_shadow", 32'(shadow), 32'h0);

    // A5 / FF from shadow 00
    in_valid = 1'b1; in_data = 8'hA5; in_mask = 8'hFF;
    tick();
    in_valid = 1'b0;
    chk("a5_sr", 32'(sr_out), 32'h8822);
    chk("a5_shadow", 32'(shadow), 32'hA5);
    chk("a5_ready", 32'(in_ready), 32'h0);
    chk("a5_busy", 32'(busy), 32'h1);
    tick();
    chk("a5_settle", 32'(sr_out), 32'h0);
    chk("a5_nodone", 32'(done), 32'h0);
    tick();
    chk("a5_done", 32'(done), 32'h1);
    chk("a5_bank", 32'(bank), 32'hA5);

    // back-to-back: 0F / F0 accepted in the done cycle
    in_valid = 1'b1; in_data = 8'h0F; in_mask = 8'hF0;
    tick();
    in_valid = 1'b0;
    chk("0f_sr", 32'(sr_out), 32'h4400);
    chk("0f_shadow", 32'(shadow), 32'h05);
    tick();
    chk("0f_settle", 32'(sr_out), 32'h0);
    tick();
    chk("0f_done", 32'(done), 32'h1);
    chk("0f_bank", 32'(bank), 32'h05);

    // no-change write: no DRIVE, done next cycle
    in_valid = 1'b1; in_data = 8'h05; in_mask = 8'hFF;
    tick();
    in_valid = 1'b0;
    chk("nc_sr", 32'(sr_out), 32'h0);
    chk("nc_ready", 32'(in_ready), 32'h1);
    chk("nc_busy", 32'(busy), 32'h0);
    chk("nc_done", 32'(done), 32'h1);
    chk("nc_shadow", 32'(shadow), 32'h05);
    tick();
    chk("nc_done_clr", 32'(done), 32'h0);

    // empty mask is a no-change write too
    in_valid = 1'b1; in_data = 8'hFF; in_mask = 8'h00;
    tick();
    in_valid = 1'b0;
    chk("m0_sr", 32'(sr_out), 32'h0);
    chk("m0_done", 32'(done), 32'h1);
    chk("m0_shadow", 32'(shadow), 32'h05);
    tick();

`ifdef SRFF_CMD_DRIVER_CHECK_EN
    stuck = 8'h08;
    in_valid = 1'b1; in_data = 8'h08; in_mask = 8'h08;
    tick();
    in_valid = 1'b0;
    chk("ck_sr", 32'(sr_out), 32'h0080);
    chk("ck_shadow", 32'(shadow), 32'h0D);
    tick();
    chk("ck_mis_pre", 32'(mismatch), 32'h0);
    tick();
    chk("ck_done", 32'(done), 32'h1);
    chk("ck_mis", 32'(mismatch), 32'h1);
    stuck = 8'h00;
    in_valid = 1'b1; in_data = 8'h00; in_mask = 8'h08;
    tick();
    in_valid = 1'b0;
    chk("ck2_sr", 32'(sr_out), 32'h0040);
    tick(); tick();
    chk("ck2_done", 32'(done), 32'h1);
    chk("ck2_mis_sticky", 32'(mismatch), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ck_mis_rst", 32'(mismatch), 32'h0);
    tick(); tick(); tick();
`else
    chk("mis_tied0", 32'(mismatch), 32'h0);
`endif

    // HOLD_CYCLES=3 instance: bring up through INIT
    rst3 = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("h3_init_done", 32'(done3), 32'h1);
    chk("h3_ready", 32'(in_ready3), 32'h1);
    in_valid3 = 1'b1; in_data3 = 8'hFF; in_mask3 = 8'hFF;
    tick();
    in_valid3 = 1'b0;
    chk("h3_drv1", 32'(sr_out3), 32'hAAAA);
    tick();
    chk("h3_drv2", 32'(sr_out3), 32'hAAAA);
    rst3 = 1'b1;
    tick();
    chk("h3_rst_sr", 32'(sr_out3), 32'h0);
    chk("h3_rst_shadow", 32'(shadow3), 32'h0);
    chk("h3_rst_ready", 32'(in_ready3), 32'h0);
    chk("h3_rst_busy", 32'(busy3), 32'h1);
    rst3 = 1'b0;
    in_valid3 = 1'b1; in_data3 = 8'h01; in_mask3 = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("h3_init_clr", 32'(sr_out3), 32'h5555);
      chk("h3_init_ready", 32'(in_ready3), 32'h0);
      chk("h3_init_shadow", 32'(shadow3), 32'h0);
    end
    tick();
    chk("h3_settle_sr", 32'(sr_out3), 32'h0);
    chk("h3_settle_ready", 32'(in_ready3), 32'h0);
    tick();
    chk("h3_idle_done", 32'(done3), 32'h1);
    chk("h3_idle_shadow", 32'(shadow3), 32'h0);
    tick();
    in_valid3 = 1'b0;
    chk("h3_held_sr", 32'(sr_out3), 32'h0002);
    chk("h3_held_shadow", 32'(shadow3), 32'h01);
    tick(); tick();
    chk("h3_hold3", 32'(sr_out3), 32'h0002);
    tick();
    chk("h3_settle2", 32'(sr_out3), 32'h0);
    tick();
    chk("h3_done2", 32'(done3), 32'h1);
    chk("h3_bank", 32'(bank3), 32'h01);
    chk("h3_mis", 32'(mismatch3), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/srff_cmd_driver.md
Name: srff_cmd_driver

Overview:
- Command-side driver for a bank of N srff-style storage flops; the write end of the SR interface.
- Accepts target-word writes over a valid/ready handshake and keeps a shadow copy of the bank state.
- Emits per-bit 2-bit sr codes: 00 = hold, 01 = clear, 10 = set. Code 11 is never driven.
- Sits between a register-write master and the SR flop bank.

Parameters:
- N, 8, number of SR flops driven.
- HOLD_CYCLES, 1, cycles each set/clear code is held; must be >= 1.
- CW, 4, width of the hold counter; HOLD_CYCLES must be <= 2**CW-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  write request.
- in_ready  output  1  block can accept a write.
- in_data  input  N  target bit values.
- in_mask  input  N  1 = bit participates in the write.
- sr_out  output  2N  bit i code on sr_out[2i+1:2i], MSB = set, LSB = clear.
- shadow  output  N  believed current flop state.
- busy  output  1  FSM not in IDLE.
- done  output  1  one-cycle pulse when a write or init completes.
- q_fb  input  N  flop outputs; used only with the optional feature.
- mismatch  output  1  sticky compare error; tied 0 without the optional feature.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; port names are clk and rst.
- Registered outputs: all outputs are registered except in_ready, which is decoded from state.
- Reset values: state = INIT, sr_out = all 00, shadow = 0, busy = 1, done = 0, mismatch = 0, hold counter = 0.
- FSM states: INIT, IDLE, DRIVE, SETTLE.
- INIT (the flops have no reset of their own):
  - drive 01 on every bit for HOLD_CYCLES cycles, then go to SETTLE;
  - shadow is 0 from reset onward.
- IDLE:
  - in_ready = 1, sr_out = 00, busy = 0;
  - a write is accepted on the cycle in_valid && in_ready.
- Per-bit command computed at accept:
  - set (10) if mask=1, data=1, shadow=0;
  - clear (01) if mask=1, data=0, shadow=1;
  - otherwise hold (00).
- Accepted write with at least one set/clear:
  - latch the commands; enter DRIVE next cycle;
  - sr_out shows the commands for exactly HOLD_CYCLES cycles;
  - shadow updates to (shadow & ~mask) | (data & mask) on the accept edge.
- Accepted write with no changing bits: stay in IDLE; done pulses on the following cycle.
- DRIVE: the counter counts 1..HOLD_CYCLES; at terminal count go to SETTLE.
- SETTLE:
  - sr_out = 00 for one cycle, then IDLE;
  - done = 1 during the IDLE-entry cycle (one cycle after SETTLE).
- in_ready = 0 in INIT, DRIVE and SETTLE; in_valid is ignored there and the write is not lost (master holds it).
- Latency:
  - accept to first code on sr_out: 1 cycle;
  - accept to done: HOLD_CYCLES + 2 cycles;
  - back-to-back writes: next accept is possible in the done cycle.
- rst asserted in any state, including mid-DRIVE: next cycle is INIT and sr_out = 00; the latched command is discarded.
- Invariant: sr_out never carries 11 on any bit in any cycle.

Optional Feature:
- Macro: SRFF_CMD_DRIVER_CHECK_EN.
- Defined:
  - in SETTLE, compare q_fb against shadow;
  - any difference sets mismatch, which is sticky until rst;
  - done still pulses.
- Undefined: no comparator, q_fb unused, mismatch tied 0.

Decomposition:
- Shared package srff_pkg:
  - sr code constants SR_HOLD = 2'b00, SR_CLR = 2'b01, SR_SET = 2'b10, SR_ILLEGAL = 2'b11;
  - FSM state encoding constants.
- One sub-module, srff_cmd_encode:
  - combinational per-bit command generation from data/mask/shadow;
  - instantiated once, N bits wide.

Test Plan:
- Reset release, HOLD_CYCLES=1 -> sr_out all 01 for 1 cycle, 00 for 1 cycle, done pulse at cycle 3, shadow=8'h00, in_ready=1 after.
- Write data=8'hA5, mask=8'hFF from shadow 00 -> bits 0,2,5,7 show 10, others 00, for 1 cycle; shadow=8'hA5; done at accept+3; srff bank q=8'hA5.
- Write data=8'h0F, mask=8'hF0 from shadow A5 -> bits 5,7 show 01, bits 0-4 and 6 show 00; shadow=8'h05.
- Write data=8'h05, mask=8'hFF with shadow 05 -> sr_out stays 00, no DRIVE, done next cycle, in_ready held 1.
- HOLD_CYCLES=3, rst asserted on the 2nd DRIVE cycle -> next cycle INIT with sr_out all 01, shadow=0; a write presented during INIT sees in_ready=0 and is not accepted.
- With SRFF_CMD_DRIVER_CHECK_EN, force q_fb bit 3 stuck at 0 and write 8'h08 -> mismatch=1 after SETTLE and remains 1 through later good writes until rst.
- All scenarios: sr_out never shows 11 on any bit in any cycle.
